uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- 8N1 UART receive path. Consumes the oversampling tick from baud_rate_generator: 16 ticks per bit, i.e. 9600 baud at 100 MHz with M=651.
- Synchronises the raw rx pin, hunts for a start bit, mid-bit samples the data and stop bits, and presents each received byte with a one-cycle strobe.
- Sits between the board rx pin and the flag/command logic.

Parameters:
DBITS, 8, number of data bits per frame, sent LSB first
OVS, 16, sample ticks per bit period
SB_TICK, 16, sample ticks spent in the stop bit (16 = 1 stop bit)

Ports:
clk_100MHz  input  1  system clock
reset  input  1  asynchronous active-high reset
rx  input  1  raw serial line, idle high, asynchronous to clk_100MHz
sample_tick  input  1  oversampling tick from baud_rate_generator; a square wave high for about half its period, not a single-cycle pulse
data_out  output  DBITS  last received byte; holds until the next frame completes
data_ready  output  1  one-cycle pulse when data_out is updated with a correctly framed byte
frame_error  output  1  one-cycle pulse when the stop bit samples low
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high) forces these values:
  - state = IDLE; data_out = 0; data_ready = 0; frame_error = 0; busy = 0.
  - Both rx synchroniser flops = 1.
  - Tick edge-detect flop = 0; tick and bit counters = 0; shift register = 0.
- rx synchroniser: two flops. rx_s is rx delayed 2 clocks. All decisions use rx_s.
- Tick qualification:
  - tick_en = sample_tick AND NOT sample_tick_d, where sample_tick_d is the tick registered once.
  - One tick_en per tick period; the tick's high duration is ignored.
  - All counting advances only on tick_en.
- Counters:
  - s_cnt, 4 bits (log2 OVS), counts ticks within a bit.
  - n_cnt, 3 bits (log2 DBITS), counts data bits.
  - Both wrap only by explicit clear; no implicit overflow is relied upon.
- States and transitions:
  - IDLE: when rx_s==0, clear s_cnt and go to START. This is the same-cycle check; no tick is needed.
  - START: on tick_en, if s_cnt==OVS/2-1 (7):
    - rx_s==0: clear s_cnt, n_cnt; go to DATA (mid start bit reached).
    - rx_s==1: glitch; go to IDLE with no outputs.
    - Otherwise s_cnt++.
  - DATA: on tick_en, if s_cnt==OVS-1:
    - Clear s_cnt; shift register = {rx_s, shreg[DBITS-1:1]} (LSB first).
    - If n_cnt==DBITS-1, go to STOP; else n_cnt++.
    - Otherwise s_cnt++.
  - STOP: on tick_en, if s_cnt==SB_TICK-1:
    - rx_s==1: data_out = shreg; pulse data_ready; go to IDLE.
    - rx_s==0: pulse frame_error; data_out unchanged; go to BREAK.
    - Otherwise s_cnt++.
  - BREAK: wait for rx_s==1 (no tick needed), then go to IDLE. This prevents a held-low line (break) from retriggering frames.
- Latency: data_ready asserts 1 clock after the tick_en that samples mid-stop-bit. That is about 9.5 bit periods after the start falling edge, plus 2 clocks of synchroniser delay and 1 clock of tick edge detect.
- data_ready and frame_error are never high in the same cycle. Each is high for exactly one clk_100MHz cycle.
- A new start bit is accepted in the clock after returning to IDLE. Back-to-back frames with no idle gap must be received.
- Reset asserted mid-frame aborts immediately, with no strobe. After release, the receiver waits for a fresh falling edge. A line already low at release is treated as a start.
- sample_tick held constant (generator in reset) freezes the FSM in its current state. No timeout.

Test Plan:
- Baud generator M=651, frame 0x55 at 10416 clk/bit -> exactly one data_ready pulse; data_out=0x55; frame_error never high; busy low afterwards.
- Frames 0x00, 0xFF, 0xA3 back-to-back, no idle gap -> three data_ready pulses in order with data_out 0x00, 0xFF, 0xA3; bits checked LSB first.
- rx low pulse of 3 tick periods (about 19.5 us) on an idle line -> returns to IDLE from START; no data_ready or frame_error; busy high for about 7 tick periods only.
- Frame 0x3C with the stop bit driven low, then rx held low 5 bit periods, then high, then frame 0x81 -> one frame_error pulse; data_out stays at its previous value through the break; no spurious frame during the break; next data_ready gives 0x81.
- Reset asserted during the 4th data bit of 0x96, released after 20 clocks with rx high; then send 0x42 -> no strobe for the aborted frame; data_out=0x00 after reset; then data_out=0x42 with one data_ready.
- sample_tick held high for 1000 clocks mid-DATA, then resumed -> only one tick_en counted per rising edge; byte still decodes correctly once the frame timing is adjusted by the bench.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receive path: synchronises rx, hunts for a start bit, mid-bit samples data and stop,
// and presents each byte with a one-cycle strobe. Counting advances on sample_tick rising edges.
module uart_receiver #(
    parameter int unsigned DBITS   = 8,
    parameter int unsigned OVS     = 16,
    parameter int unsigned SB_TICK = 16
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             rx,
    input  logic             sample_tick,
    output logic [DBITS-1:0] data_out,
    output logic             data_ready,
    output logic             frame_error,
    output logic             busy
);

    localparam int unsigned SCntMax = (SB_TICK > OVS) ? SB_TICK : OVS;
    localparam int unsigned SW      = (SCntMax > 2) ? $clog2(SCntMax) : 1;
    localparam int unsigned NW      = (DBITS > 2) ? $clog2(DBITS) : 1;

    localparam logic [SW-1:0] SHalf = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] SBit  = SW'(OVS - 1);
    localparam logic [SW-1:0] SStop = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] NLast = NW'(DBITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    s_cnt_q, s_cnt_d;
    logic [NW-1:0]    n_cnt_q, n_cnt_d;
    logic [DBITS-1:0] shreg_q, shreg_d;
    logic [DBITS-1:0] data_q, data_d;
    logic             ready_q, ready_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;
    logic             rx_meta_q, rx_s_q;
    logic             tick_d_q;
    logic             tick_en;

    // The generator's tick is a square wave; only its rising edge counts.
    assign tick_en = sample_tick & ~tick_d_q;

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    s_cnt_d = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick_en) begin
                    if (s_cnt_q == SHalf) begin
                        if (!rx_s_q) begin
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                            state_d = StData;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (tick_en) begin
                    if (s_cnt_q == SBit) begin
                        s_cnt_d = '0;
                        shreg_d = {rx_s_q, shreg_q[DBITS-1:1]};
                        if (n_cnt_q == NLast) begin
                            state_d = StStop;
                        end else begin
                            n_cnt_d = n_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (tick_en) begin
                    if (s_cnt_q == SStop) begin
                        if (rx_s_q) begin
                            data_d  = shreg_q;
                            ready_d = 1'b1;
                            state_d = StIdle;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = StBreak;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            StBreak: begin
                // A line held low must return high before a new start is hunted.
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            s_cnt_q   <= '0;
            n_cnt_q   <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            tick_d_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            n_cnt_q   <= n_cnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            tick_d_q  <= sample_tick;
        end
    end

    assign data_out    = data_q;
    assign data_ready  = ready_q;
    assign frame_error = ferr_q;
    assign busy        = busy_q;

endmodule
